bk_operand_feeder: RTL and testbench

BK_OPERAND_FEEDER -- requirements
Module: bk_operand_feeder

---
 rtl/bk_operand_feeder.sv | 88 ++++++++
 tb/tb_bk_operand_feeder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bk_operand_feeder.sv
// Operand FIFO and result register wrapped around an external Brent-Kung adder.
// The FIFO head is presented bit-interleaved on add_inputs; the returned sum is captured on pop.
module bk_operand_feeder #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_a,
   input  logic [WIDTH-1:0]         in_b,
   output logic [2*WIDTH-1:0]       add_inputs,
   input  logic [WIDTH:0]           add_outs,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH:0]           out_sum,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     busy
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             empty;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;

   // in_ready depends only on level, so out_ready never reaches it combinationally
   assign empty    = (level == '0);
   assign in_ready = (level < LW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = !empty && (!out_valid || out_ready);
   assign busy     = !empty || out_valid;

   assign head_a = empty ? '0 : mem_a[rd_ptr];
   assign head_b = empty ? '0 : mem_b[rd_ptr];

   for (genvar i = 0; i < WIDTH; i++) begin : g_ilv
      assign add_inputs[2*i]   = head_a[i];
      assign add_inputs[2*i+1] = head_b[i];
   end

   // Storage is left unreset; it is only read through the empty-gated head.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_a[wr_ptr] <= in_a;
         mem_b[wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (pop) begin
            out_sum   <= add_outs;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bk_operand_feeder.sv
// Directed bench for bk_operand_feeder with a behavioural adder attached to the interleaved bus.
module tb_bk_operand_feeder;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      in_a;
   logic [WIDTH-1:0]      in_b;
   logic [2*WIDTH-1:0]    add_inputs;
   logic [WIDTH:0]        add_outs;
   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH:0]        out_sum;
   logic [2:0]            level;
   logic                  busy;

   int tests = 0;
   int fails = 0;

   bk_operand_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .add_inputs(add_inputs), .add_outs(add_outs),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .level(level), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference adder: de-interleave and add
   logic [WIDTH-1:0] ma, mb;
   always_comb begin
      ma = '0;
      mb = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ma[i] = add_inputs[2*i];
         mb[i] = add_inputs[2*i+1];
      end
      add_outs = {1'b0, ma} + {1'b0, mb};
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] sum13(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return 32'(s);
   endfunction

   logic [WIDTH-1:0] pa [6];
   logic [WIDTH-1:0] pb [6];
   logic [31:0]      expq [$];
   logic [31:0]      ex;
   int               sent, rcvd, cyc, max_lvl;

   initial begin
      // Reset with in_valid high, before any clock edge
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_a = 12'hABC; in_b = 12'h123; out_ready = 1'b0;
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_add_inputs", 32'(add_inputs), 32'h000000);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      tick();
      in_valid = 1'b0;
      chk("rst_hold_level", 32'(level), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single operation
      out_ready = 1'b1; in_valid = 1'b1; in_a = 12'hFFF; in_b = 12'h001;
      tick();
      in_valid = 1'b0;
      chk("single_add_inputs", 32'(add_inputs), 32'h555557);
      chk("single_level1", 32'(level), 32'd1);
      chk("single_not_yet", 32'(out_valid), 32'd0);
      tick();
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_sum", 32'(out_sum), 32'h1000);
      chk("single_empty_bus", 32'(add_inputs), 32'h0);
      tick();
      chk("single_drop", 32'(out_valid), 32'd0);
      chk("single_sum_hold", 32'(out_sum), 32'h1000);
      chk("single_idle", 32'(busy), 32'd0);

      // Backpressure
      for (int k = 0; k < 6; k++) begin
         pa[k] = 12'(12'h0F3 * (k + 1) + 12'h800);
         pb[k] = 12'(12'h1A5 * (k + 2));
      end
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_a = pa[k]; in_b = pb[k];
         tick();
      end
      in_a = pa[5]; in_b = pb[5];
      chk("bp_level4", 32'(level), 32'd4);
      chk("bp_in_ready0", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum0", 32'(out_sum), sum13(pa[0], pb[0]));
      tick();
      tick();
      chk("bp_stall_level", 32'(level), 32'd4);
      chk("bp_stable_sum", 32'(out_sum), sum13(pa[0], pb[0]));
      chk("bp_stable_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("bp_sum1", 32'(out_sum), sum13(pa[1], pb[1]));
      chk("bp_level3", 32'(level), 32'd3);
      chk("bp_ready_again", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_sum2", 32'(out_sum), sum13(pa[2], pb[2]));
      chk("bp_p6_accepted", 32'(level), 32'd3);
      for (int k = 3; k < 6; k++) begin
         tick();
         chk("bp_sum_seq", 32'(out_sum), sum13(pa[k], pb[k]));
         chk("bp_valid_seq", 32'(out_valid), 32'd1);
      end
      tick();
      chk("bp_done", 32'(out_valid), 32'd0);
      chk("bp_level0", 32'(level), 32'd0);

      // Flush with level 3, out_valid 1, push offered on the flush edge
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_a = pa[k] ^ 12'h5A5; in_b = pb[k];
         tick();
      end
      chk("fl_pre_level", 32'(level), 32'd3);
      chk("fl_pre_valid", 32'(out_valid), 32'd1);
      ex = sum13(pa[0] ^ 12'h5A5, pb[0]);
      flush = 1'b1; in_a = 12'h777; in_b = 12'h111;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_level", 32'(level), 32'd0);
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_sum_kept", 32'(out_sum), ex);
      chk("fl_bus_zero", 32'(add_inputs), 32'h0);
      out_ready = 1'b1; in_valid = 1'b1; in_a = 12'h9C4; in_b = 12'h7D3;
      tick();
      in_valid = 1'b0;
      chk("fl_post_level", 32'(level), 32'd1);
      tick();
      chk("fl_post_sum", 32'(out_sum), 32'h1197);
      chk("fl_post_valid", 32'(out_valid), 32'd1);
      tick();
      chk("fl_no_stale", 32'(out_valid), 32'd0);

      // Random streaming with scoreboard
      sent = 0; rcvd = 0; cyc = 0; max_lvl = 0;
      while ((rcvd < 1000) && (cyc < 20000)) begin
         in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         out_ready = 1'($urandom_range(0, 1));
         in_a      = 12'($urandom);
         in_b      = 12'($urandom);
         #1;
         if (int'(level) > max_lvl) max_lvl = int'(level);
         if (in_valid && in_ready) begin
            expq.push_back(sum13(in_a, in_b));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("st_unexpected", 32'(out_sum), 32'hFFFF_FFFF);
            else chk("st_sum", 32'(out_sum), expq.pop_front());
            rcvd++;
         end
         tick();
         cyc++;
      end
      chk("st_all_received", 32'(rcvd), 32'd1000);
      chk("st_queue_empty", 32'(expq.size()), 32'd0);
      chk("st_max_level", 32'(max_lvl <= DEPTH), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      tick();
      chk("st_idle", 32'(busy), 32'd0);

      // Async reset between edges, mid-stream
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_a = pa[k]; in_b = pb[k];
         tick();
      end
      chk("ar_pre_level", 32'(level), 32'd2);
      chk("ar_pre_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_level", 32'(level), 32'd0);
      chk("ar_sum", 32'(out_sum), 32'd0);
      chk("ar_in_ready", 32'(in_ready), 32'd1);
      chk("ar_bus", 32'(add_inputs), 32'h0);
      chk("ar_busy", 32'(busy), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1; in_valid = 1'b1; in_a = 12'h321; in_b = 12'hEDF;
      tick();
      in_valid = 1'b0;
      tick();
      chk("ar_post_sum", 32'(out_sum), 32'h1200);
      chk("ar_post_valid", 32'(out_valid), 32'd1);
      tick();
      chk("ar_post_drain", 32'(out_valid), 32'd0);
      chk("ar_post_level", 32'(level), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
